// File: rtl/nn_pkg.sv
// Shared widths, sequencer state encoding and the ReLU/saturate helper.
// Declarations only: no latency or backpressure of its own.
package nn_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;
   localparam int ACC_W_DEF  = 20;
   localparam int OUT_W_DEF  = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_OUT  = 2'd2;

   // Negative clips to 0, anything above the signed out_w maximum clamps to it.
   function automatic logic signed [63:0] relu_sat(input logic signed [63:0] v,
                                                   input int out_w);
      logic signed [63:0] maxv;
      maxv = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      if (v < 64'sd0)
         return '0;
      if (v > maxv)
         return maxv;
      return v;
   endfunction

endpackage

// File: rtl/neuron_mac_sequencer_if.sv
// Layer-controller, weight-ROM, activation-buffer and result handshake bundle.
// Wires only; latency and backpressure are set by the sequencer.
interface neuron_mac_sequencer_if
   import nn_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int OUT_W  = OUT_W_DEF
);
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic              busy;
   logic [ADDR_W-1:0] rom_addr;
   logic              rom_en;
   logic [DATA_W-1:0] rom_data;
   logic [ADDR_W-1:0] x_addr;
   logic [DATA_W-1:0] x_data;
   logic              out_valid;
   logic              out_ready;
   logic [OUT_W-1:0]  out_data;
   logic [ACC_W-1:0]  acc_dbg;

   modport master (
      input  start, base_addr, rom_data, x_data, out_ready,
      output busy, rom_addr, rom_en, x_addr, out_valid, out_data, acc_dbg
   );

   modport slave (
      output start, base_addr, rom_data, x_data, out_ready,
      input  busy, rom_addr, rom_en, x_addr, out_valid, out_data, acc_dbg
   );
endinterface

// File: rtl/neuron_mac_sequencer_mac.sv
// Registered signed multiply-accumulate; one cycle per product, clr wins over en.
// No backpressure: accumulates on every enabled edge.
module mac_unit #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 20
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     en,
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   output logic signed [ACC_W-1:0]  acc
);
   logic signed [2*DATA_W-1:0] prod;

   assign prod = a * b;

   // Size cast of a signed product sign-extends; the sum wraps at ACC_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc <= '0;
      else if (clr)
         acc <= '0;
      else if (en)
         acc <= acc + ACC_W'(prod);
   end
endmodule

// File: rtl/neuron_mac_sequencer.sv
// One neuron: N_INPUTS MAC cycles over ROM/activations, then shift, ReLU, saturate.
// Result valid N_INPUTS edges after start; held stable until out_ready; start ignored while busy.
module neuron_mac_sequencer
   import nn_pkg::*;
#(
   parameter int N_INPUTS = 8,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ACC_W    = ACC_W_DEF,
   parameter int OUT_W    = OUT_W_DEF,
   parameter int SHIFT    = 0
)(
   input logic                    clk,
   input logic                    rst_n,
   neuron_mac_sequencer_if.master bus
);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_INPUTS - 1);

   logic [1:0]               state;
   logic [ADDR_W-1:0]        idx;
   logic [ADDR_W-1:0]        base_q;
   logic                     run;
   logic                     mac_clr;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  acc_sh;

   assign run     = (state == ST_RUN);
   assign mac_clr = (state == ST_IDLE) && bus.start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         idx    <= '0;
         base_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  state  <= ST_RUN;
                  base_q <= bus.base_addr;
                  idx    <= '0;
               end
            end
            ST_RUN: begin
               idx <= idx + 1'b1;
               if (idx == LAST_IDX)
                  state <= ST_OUT;
            end
            ST_OUT: begin
               if (bus.out_ready)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // ROM drives Z outside RUN, so the MAC only samples rom_data while run is high.
   mac_unit #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (mac_clr),
      .en    (run),
      .a     (bus.rom_data),
      .b     (bus.x_data),
      .acc   (acc)
   );

   assign acc_sh = acc >>> SHIFT;

   assign bus.busy      = (state != ST_IDLE);
   assign bus.rom_en    = run;
   assign bus.rom_addr  = run ? (base_q + idx) : '0;
   assign bus.x_addr    = run ? idx : '0;
   assign bus.out_valid = (state == ST_OUT);
   assign bus.out_data  = bus.out_valid ? OUT_W'(relu_sat(64'(acc_sh), OUT_W)) : '0;
   assign bus.acc_dbg   = acc;
endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Bench: three 8-input sequencers (SHIFT 0/1/2) share stimulus; a 4-input one checks address wrap.
// Expected results come from a plain-arithmetic dot-product model over the ROM/activation arrays.
module tb_neuron_mac_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       start, out_ready;
   logic [7:0] base_addr;
   logic       start3, ready3;
   logic [7:0] base3;

   logic [7:0] rom [256];
   logic [7:0] xb  [256];

   int n_cmp = 0;
   int n_err = 0;

   neuron_mac_sequencer_if if0 ();
   neuron_mac_sequencer_if if1 ();
   neuron_mac_sequencer_if if2 ();
   neuron_mac_sequencer_if if3 ();

   assign if0.start = start;  assign if0.base_addr = base_addr;  assign if0.out_ready = out_ready;
   assign if1.start = start;  assign if1.base_addr = base_addr;  assign if1.out_ready = out_ready;
   assign if2.start = start;  assign if2.base_addr = base_addr;  assign if2.out_ready = out_ready;
   assign if3.start = start3; assign if3.base_addr = base3;      assign if3.out_ready = ready3;

   assign if0.rom_data = if0.rom_en ? rom[if0.rom_addr] : 8'bz;
   assign if1.rom_data = if1.rom_en ? rom[if1.rom_addr] : 8'bz;
   assign if2.rom_data = if2.rom_en ? rom[if2.rom_addr] : 8'bz;
   assign if3.rom_data = if3.rom_en ? rom[if3.rom_addr] : 8'bz;
   assign if0.x_data = xb[if0.x_addr];
   assign if1.x_data = xb[if1.x_addr];
   assign if2.x_data = xb[if2.x_addr];
   assign if3.x_data = xb[if3.x_addr];

   neuron_mac_sequencer #(.N_INPUTS(8), .SHIFT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   neuron_mac_sequencer #(.N_INPUTS(8), .SHIFT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   neuron_mac_sequencer #(.N_INPUTS(8), .SHIFT(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
   neuron_mac_sequencer #(.N_INPUTS(4), .SHIFT(0)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Dot product of n weights from base (address wraps mod 256) with x[0..n-1], wrapped to 20 bits.
   function automatic int model_acc(input logic [7:0] base, input int n);
      int s, w, a;
      logic [7:0] ra;
      s = 0;
      for (int i = 0; i < n; i++) begin
         ra = base + 8'(i);
         w  = int'($signed(rom[ra]));
         a  = int'($signed(xb[i]));
         s += w * a;
      end
      s = s & 'hFFFFF;
      if (s >= 'h80000) s -= 'h100000;
      return s;
   endfunction

   function automatic int model_out(input int acc, input int sh);
      int v;
      v = acc >>> sh;
      if (v < 0)   return 0;
      if (v > 127) return 127;
      return v;
   endfunction

   function automatic logic [63:0] acc20(input int v);
      return {44'd0, v[19:0]};
   endfunction

   task automatic check_idle_zero(input string tag);
      check({tag, "_busy"},  64'(if0.busy), 0);
      check({tag, "_rom_en"}, 64'(if0.rom_en), 0);
      check({tag, "_rom_addr"}, 64'(if0.rom_addr), 0);
      check({tag, "_x_addr"}, 64'(if0.x_addr), 0);
      check({tag, "_out_valid"}, 64'(if0.out_valid), 0);
      check({tag, "_out_data"}, 64'(if0.out_data), 0);
      check({tag, "_acc_dbg"}, 64'(if0.acc_dbg), 0);
   endtask

   // One neuron on dut0..2: valid exactly 8 edges after the start edge, hold for `hold` cycles.
   task automatic run_main(input logic [7:0] base, input string tag, input int hold, input bit coincide);
      int ea;
      ea = model_acc(base, 8);
      @(negedge clk); start = 1'b1; base_addr = base; out_ready = 1'b0;
      @(negedge clk); start = 1'b0;
      repeat (7) @(negedge clk);
      check({tag, "_valid_early"}, 64'(if0.out_valid), 0);
      @(negedge clk);
      check({tag, "_valid"}, 64'(if0.out_valid), 1);
      check({tag, "_acc"}, 64'(if0.acc_dbg), acc20(ea));
      check({tag, "_out_s0"}, 64'(if0.out_data), 64'(model_out(ea, 0)));
      check({tag, "_out_s1"}, 64'(if1.out_data), 64'(model_out(ea, 1)));
      check({tag, "_out_s2"}, 64'(if2.out_data), 64'(model_out(ea, 2)));
      for (int k = 0; k < hold; k++) begin
         start = (k % 2 == 1);
         @(negedge clk);
         check({tag, "_hold_valid"}, 64'(if0.out_valid), 1);
         check({tag, "_hold_out"}, 64'(if0.out_data), 64'(model_out(ea, 0)));
         check({tag, "_hold_acc"}, 64'(if0.acc_dbg), acc20(ea));
      end
      start = coincide; out_ready = 1'b1;
      @(negedge clk); start = 1'b0; out_ready = 1'b0;
      check({tag, "_drop_valid"}, 64'(if0.out_valid), 0);
      check({tag, "_idle"}, 64'(if0.busy), 0);
      @(negedge clk);
      check({tag, "_start_ignored"}, 64'(if0.busy), 0);
   endtask

   task automatic load_vec();
      int wv[8];
      wv = '{1, 3, 2, 5, 6, 5, 5, 2};
      for (int i = 0; i < 8; i++) begin
         rom[i] = 8'(wv[i]);
         xb[i]  = 8'(i + 1);
      end
   endtask

   initial begin
      int ea3;
      int en_cnt;
      logic [7:0] rb;
      rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; base_addr = 8'h00;
      start3 = 1'b0; ready3 = 1'b1; base3 = 8'h00;
      for (int i = 0; i < 256; i++) begin
         rom[i] = 8'($urandom);
         xb[i]  = 8'($urandom);
      end
      repeat (3) @(negedge clk);
      check_idle_zero("reset");
      rst_n = 1'b1;

      // Directed vector: saturates at SHIFT 0; backpressure window with ignored start pulses.
      load_vec();
      run_main(8'h00, "vec", 5, 1'b1);

      // All activations -1: negative accumulator, ReLU to zero.
      for (int i = 0; i < 8; i++) xb[i] = 8'hFF;
      run_main(8'h00, "neg", 0, 1'b0);

      // Address wrap on the 4-input instance.
      ea3 = model_acc(8'hFE, 4);
      en_cnt = 0;
      @(negedge clk); start3 = 1'b1; base3 = 8'hFE;
      @(negedge clk); start3 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         rb = 8'hFE + 8'(k);
         if (if3.rom_en) en_cnt++;
         check("wrap_rom_addr", 64'(if3.rom_addr), 64'(rb));
         check("wrap_x_addr", 64'(if3.x_addr), 64'(k));
         @(negedge clk);
      end
      if (if3.rom_en) en_cnt++;
      check("wrap_rom_en_cycles", 64'(en_cnt), 4);
      check("wrap_rom_addr_off", 64'(if3.rom_addr), 0);
      check("wrap_valid", 64'(if3.out_valid), 1);
      check("wrap_out", 64'(if3.out_data), 64'(model_out(ea3, 0)));
      @(negedge clk);
      check("wrap_accept", 64'(if3.busy), 0);

      // Randomized neurons against the model.
      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < 256; i++) begin
            rom[i] = 8'($urandom);
            xb[i]  = 8'($urandom);
         end
         run_main(8'($urandom), "rnd", int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      end

      // Asynchronous reset in the middle of RUN, then a clean rerun.
      load_vec();
      @(negedge clk); start = 1'b1; base_addr = 8'h00;
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      check("midrun_idx", 64'(if0.x_addr), 3);
      rst_n = 1'b0;
      #1;
      check_idle_zero("midrun_rst");
      @(negedge clk); rst_n = 1'b1;
      run_main(8'h00, "post_rst", 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
